tlb_unit: RTL and testbench

- 16-entry, fully associative MIPS32-style joint TLB, 4 KB pages, no PageMask.
- Consumes the CP0 MMU view (Index, EntryHi, EntryLo0, EntryLo1) to execute TLBP/TLBR/TLBWI.
- Returns results to CP0 through the w_cp0_mmu_ena / w_cp0_Index / w_cp0_EntryHi / w_cp0_EntryLo0/1 write path.
- Serves registered instruction-fetch and data address translations, whose fault flags feed exception generation.

---
 rtl/tlb_pkg.sv | 60 ++++++
 rtl/tlb_lookup.sv | 31 +++
 rtl/tlb_unit.sv | 176 +++++++++++++++++
 tb/tb_tlb_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared definitions for the 16-entry joint TLB: op codes, entry layout,
// EntryLo field positions and the unmapped kseg0/kseg1 window.
package tlb_pkg;

  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  localparam logic [1:0] TLBOP_P  = 2'd0;
  localparam logic [1:0] TLBOP_R  = 2'd1;
  localparam logic [1:0] TLBOP_WI = 2'd2;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  localparam int LO_PFN_LSB = 6;
  localparam int LO_C_LSB   = 3;
  localparam int LO_D_BIT   = 2;
  localparam int LO_V_BIT   = 1;
  localparam int LO_G_BIT   = 0;

  localparam logic [31:0] UNMAPPED_LO = 32'h8000_0000;
  localparam logic [31:0] UNMAPPED_HI = 32'hBFFF_FFFF;

  localparam logic [C_W-1:0] C_UNCACHED = 3'd2;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    tlb_page_t         p0;
    tlb_page_t         p1;
  } tlb_entry_t;

  function automatic tlb_page_t lo_to_page(input logic [31:0] lo);
    tlb_page_t p;
    p.pfn = lo[LO_PFN_LSB +: PFN_W];
    p.c   = lo[LO_C_LSB +: C_W];
    p.d   = lo[LO_D_BIT];
    p.v   = lo[LO_V_BIT];
    return p;
  endfunction

  function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
    return {6'b0, p.pfn, p.c, p.d, p.v, g};
  endfunction

  function automatic logic is_unmapped(input logic [31:0] va);
    return (va >= UNMAPPED_LO) && (va <= UNMAPPED_HI);
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Combinational associative match over all entries, lowest index wins,
// then odd/even page selection on the winning entry.
module tlb_lookup
  import tlb_pkg::*;
(
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [VPN2_W-1:0]       vpn2,
  input  logic [ASID_W-1:0]       asid,
  input  logic                    odd,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output tlb_page_t               page
);

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    page = '0;
    // Scan downwards so the last assignment is the lowest matching index.
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (hit) begin
      page = odd ? entries[idx].p1 : entries[idx].p0;
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// MIPS32-style 16-entry joint TLB: TLBP/TLBR/TLBWI against the CP0 view,
// plus registered one-cycle fetch and data address translation.
module tlb_unit
  import tlb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  output logic        w_cp0_mmu_ena,
  output logic [31:0] w_cp0_Index,
  output logic [31:0] w_cp0_EntryHi,
  output logic [31:0] w_cp0_EntryLo0,
  output logic [31:0] w_cp0_EntryLo1,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_resp,
  output logic [31:0] i_paddr,
  output logic        i_refill,
  output logic        i_invalid,
  output logic        i_uncached,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        d_store,
  output logic        d_resp,
  output logic [31:0] d_paddr,
  output logic        d_refill,
  output logic        d_invalid,
  output logic        d_modified,
  output logic        d_uncached
);

  tlb_entry_t [TLBNUM-1:0] entries;

  logic             i_hit, d_hit, p_hit;
  logic [IDX_W-1:0] i_idx, d_idx, p_idx;
  tlb_page_t        i_page, d_page, p_page;

  logic             op_p, op_r, op_wi;
  tlb_entry_t       wr_entry, rd_entry;
  logic             i_unm, d_unm;
  logic             mmu_ena_q, i_resp_q, d_resp_q;
  logic             unused_ok;

  assign op_p  = op_valid && (op_code == TLBOP_P);
  assign op_r  = op_valid && (op_code == TLBOP_R);
  assign op_wi = op_valid && (op_code == TLBOP_WI);

  assign i_unm = is_unmapped(i_vaddr);
  assign d_unm = is_unmapped(d_vaddr);

  tlb_lookup u_fetch (
    .entries (entries),
    .vpn2    (i_vaddr[31:13]),
    .asid    (cp0_entryhi[7:0]),
    .odd     (i_vaddr[12]),
    .hit     (i_hit),
    .idx     (i_idx),
    .page    (i_page)
  );

  tlb_lookup u_data (
    .entries (entries),
    .vpn2    (d_vaddr[31:13]),
    .asid    (cp0_entryhi[7:0]),
    .odd     (d_vaddr[12]),
    .hit     (d_hit),
    .idx     (d_idx),
    .page    (d_page)
  );

  tlb_lookup u_probe (
    .entries (entries),
    .vpn2    (cp0_entryhi[31:13]),
    .asid    (cp0_entryhi[7:0]),
    .odd     (1'b0),
    .hit     (p_hit),
    .idx     (p_idx),
    .page    (p_page)
  );

  always_comb begin
    wr_entry      = '0;
    wr_entry.vpn2 = cp0_entryhi[31:13];
    wr_entry.asid = cp0_entryhi[7:0];
    wr_entry.g    = cp0_entrylo0[LO_G_BIT] & cp0_entrylo1[LO_G_BIT];
    wr_entry.p0   = lo_to_page(cp0_entrylo0);
    wr_entry.p1   = lo_to_page(cp0_entrylo1);
  end

  assign rd_entry = entries[cp0_index[IDX_W-1:0]];

  // Entry array: writes land at the edge, so same-cycle lookups see old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries <= '0;
    end else if (op_wi) begin
      entries[cp0_index[IDX_W-1:0]] <= wr_entry;
    end
  end

  // CP0 result stage: one cycle after TLBP/TLBR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmu_ena_q      <= 1'b0;
      w_cp0_Index    <= '0;
      w_cp0_EntryHi  <= '0;
      w_cp0_EntryLo0 <= '0;
      w_cp0_EntryLo1 <= '0;
    end else begin
      mmu_ena_q <= op_p || op_r;
      if (op_p) begin
        w_cp0_Index    <= p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
        w_cp0_EntryHi  <= cp0_entryhi;
        w_cp0_EntryLo0 <= cp0_entrylo0;
        w_cp0_EntryLo1 <= cp0_entrylo1;
      end else if (op_r) begin
        w_cp0_Index    <= cp0_index;
        w_cp0_EntryHi  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
        w_cp0_EntryLo0 <= page_to_lo(rd_entry.p0, rd_entry.g);
        w_cp0_EntryLo1 <= page_to_lo(rd_entry.p1, rd_entry.g);
      end
    end
  end

  // Fetch translation stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_resp_q   <= 1'b0;
      i_paddr    <= '0;
      i_refill   <= 1'b0;
      i_invalid  <= 1'b0;
      i_uncached <= 1'b0;
    end else begin
      i_resp_q   <= i_req;
      i_paddr    <= !i_req ? '0 :
                    i_unm  ? {3'b0, i_vaddr[28:0]} : {i_page.pfn, i_vaddr[11:0]};
      i_refill   <= i_req && !i_unm && !i_hit;
      i_invalid  <= i_req && !i_unm && i_hit && !i_page.v;
      i_uncached <= i_req && (i_unm ? i_vaddr[29] : (i_page.c == C_UNCACHED));
    end
  end

  // Data translation stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_resp_q   <= 1'b0;
      d_paddr    <= '0;
      d_refill   <= 1'b0;
      d_invalid  <= 1'b0;
      d_modified <= 1'b0;
      d_uncached <= 1'b0;
    end else begin
      d_resp_q   <= d_req;
      d_paddr    <= !d_req ? '0 :
                    d_unm  ? {3'b0, d_vaddr[28:0]} : {d_page.pfn, d_vaddr[11:0]};
      d_refill   <= d_req && !d_unm && !d_hit;
      d_invalid  <= d_req && !d_unm && d_hit && !d_page.v;
      d_modified <= d_req && !d_unm && d_store && d_hit && d_page.v && !d_page.d;
      d_uncached <= d_req && (d_unm ? d_vaddr[29] : (d_page.c == C_UNCACHED));
    end
  end

  // Reset cancels a pulse or response already sitting in the output stage.
  assign w_cp0_mmu_ena = mmu_ena_q && !rst;
  assign i_resp        = i_resp_q && !rst;
  assign d_resp        = d_resp_q && !rst;

  assign unused_ok = ^{i_idx, d_idx, p_page, cp0_entryhi[12:8],
                       cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: directed stimulus pushes expectations,
// an independent monitor pops and compares on every response or CP0 pulse.
`timescale 1ns/1ps
module tb_tlb_unit;

  typedef struct packed {
    logic [31:0] paddr;
    logic        refill;
    logic        invalid;
    logic        modified;
    logic        uncached;
    logic        chk;
  } xl_t;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } cp0_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cp0_index = '0, cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd3;
  logic        w_cp0_mmu_ena;
  logic [31:0] w_cp0_Index, w_cp0_EntryHi, w_cp0_EntryLo0, w_cp0_EntryLo1;
  logic        i_req = 1'b0;
  logic [31:0] i_vaddr = '0;
  logic        i_resp, i_refill, i_invalid, i_uncached;
  logic [31:0] i_paddr;
  logic        d_req = 1'b0, d_store = 1'b0;
  logic [31:0] d_vaddr = '0;
  logic        d_resp, d_refill, d_invalid, d_modified, d_uncached;
  logic [31:0] d_paddr;

  xl_t  iq[$];
  xl_t  dq[$];
  cp0_t cq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  tlb_unit dut (
    .clk(clk), .rst(rst),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .op_valid(op_valid), .op_code(op_code),
    .w_cp0_mmu_ena(w_cp0_mmu_ena), .w_cp0_Index(w_cp0_Index),
    .w_cp0_EntryHi(w_cp0_EntryHi), .w_cp0_EntryLo0(w_cp0_EntryLo0),
    .w_cp0_EntryLo1(w_cp0_EntryLo1),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_resp(i_resp), .i_paddr(i_paddr),
    .i_refill(i_refill), .i_invalid(i_invalid), .i_uncached(i_uncached),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_store(d_store), .d_resp(d_resp),
    .d_paddr(d_paddr), .d_refill(d_refill), .d_invalid(d_invalid),
    .d_modified(d_modified), .d_uncached(d_uncached)
  );

  always #5 clk = ~clk;

  function automatic xl_t ok(input logic [31:0] pa, input logic unc);
    xl_t e;
    e = '{paddr: pa, refill: 1'b0, invalid: 1'b0, modified: 1'b0, uncached: unc, chk: 1'b1};
    return e;
  endfunction

  function automatic xl_t fault(input logic rf, input logic inv, input logic md);
    xl_t e;
    e = '{paddr: 32'h0, refill: rf, invalid: inv, modified: md, uncached: 1'b0, chk: 1'b0};
    return e;
  endfunction

  task automatic cmp_xl(input string nm, input xl_t e, input xl_t a);
    logic good;
    n_cmp++;
    good = (a.refill === e.refill) && (a.invalid === e.invalid) && (a.modified === e.modified);
    if (e.chk) good = good && (a.paddr === e.paddr) && (a.uncached === e.uncached);
    if (!good) begin
      n_bad++;
      $display("FAIL %s: got pa=%h rf=%b inv=%b mod=%b unc=%b, want pa=%h rf=%b inv=%b mod=%b unc=%b (pa/unc checked=%b)",
               nm, a.paddr, a.refill, a.invalid, a.modified, a.uncached,
               e.paddr, e.refill, e.invalid, e.modified, e.uncached, e.chk);
    end
  endtask

  // Monitor: samples 2ns after each rising edge.
  always @(posedge clk) begin
    xl_t  e, a;
    cp0_t ec, ac;
    #2;
    if (i_resp) begin
      a = '{paddr: i_paddr, refill: i_refill, invalid: i_invalid, modified: 1'b0,
            uncached: i_uncached, chk: 1'b1};
      if (iq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL i_unexpected: got i_resp=1, want no response");
      end else begin
        e = iq.pop_front();
        cmp_xl("i_xlate", e, a);
      end
    end
    if (d_resp) begin
      a = '{paddr: d_paddr, refill: d_refill, invalid: d_invalid, modified: d_modified,
            uncached: d_uncached, chk: 1'b1};
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL d_unexpected: got d_resp=1, want no response");
      end else begin
        e = dq.pop_front();
        cmp_xl("d_xlate", e, a);
      end
    end
    if (w_cp0_mmu_ena) begin
      ac = '{index: w_cp0_Index, hi: w_cp0_EntryHi, lo0: w_cp0_EntryLo0, lo1: w_cp0_EntryLo1};
      if (cq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cp0_unexpected: got mmu_ena=1 index=%h, want no pulse", w_cp0_Index);
      end else begin
        ec = cq.pop_front();
        n_cmp++;
        if (ac !== ec) begin
          n_bad++;
          $display("FAIL cp0_write: got idx=%h hi=%h lo0=%h lo1=%h, want idx=%h hi=%h lo0=%h lo1=%h",
                   ac.index, ac.hi, ac.lo0, ac.lo1, ec.index, ec.hi, ec.lo0, ec.lo1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 2'd3;
    i_req    = 1'b0;
    d_req    = 1'b0;
    d_store  = 1'b0;
  endtask

  task automatic set_cp0(input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
    cp0_index = idx; cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
  endtask

  task automatic op(input logic [1:0] code);
    op_valid = 1'b1;
    op_code  = code;
  endtask

  task automatic dreq(input logic [31:0] va, input logic st, input xl_t e);
    d_req = 1'b1; d_vaddr = va; d_store = st;
    dq.push_back(e);
  endtask

  task automatic ireq(input logic [31:0] va, input xl_t e);
    i_req = 1'b1; i_vaddr = va;
    iq.push_back(e);
  endtask

  task automatic check_empty(input string nm, input int sz);
    n_cmp++;
    if (sz != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d responses still outstanding, want 0", nm, sz);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100us, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [201:0] outs;
    repeat (3) @(negedge clk);
    outs = {w_cp0_mmu_ena, w_cp0_Index, w_cp0_EntryHi, w_cp0_EntryLo0, w_cp0_EntryLo1,
            i_resp, i_paddr, i_refill, i_invalid, i_uncached,
            d_resp, d_paddr, d_refill, d_invalid, d_modified, d_uncached};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want all zero", outs);
    end
    rst = 1'b0;

    // Empty TLB: mapped fetch refills, probe misses
    ireq(32'h0040_0000, fault(1'b1, 1'b0, 1'b0));
    step();
    set_cp0(32'd3, 32'h0040_0005, 32'h0000_1016, 32'h0);
    op(2'd0);
    cq.push_back('{index: 32'h8000_0000, hi: 32'h0040_0005, lo0: 32'h0000_1016, lo1: 32'h0});
    step();

    // Write entry 3: even page PFN 0x40, C=2, D=1, V=1; odd page invalid
    op(2'd2);
    step();
    dreq(32'h0040_0123, 1'b0, ok(32'h0004_0123, 1'b1));
    step();
    cp0_entryhi = 32'h0000_0006;
    dreq(32'h0040_0123, 1'b0, fault(1'b1, 1'b0, 1'b0));
    step();
    cp0_entryhi = 32'h0040_0005;
    op(2'd0);
    cq.push_back('{index: 32'd3, hi: 32'h0040_0005, lo0: 32'h0000_1016, lo1: 32'h0});
    step();
    ireq(32'h0040_1000, fault(1'b0, 1'b1, 1'b0));
    step();
    op(2'd1);
    cq.push_back('{index: 32'd3, hi: 32'h0040_0005, lo0: 32'h0000_1016, lo1: 32'h0});
    step();

    // Global entry 7 via index 0x17, probed immediately after the write
    set_cp0(32'h17, 32'h0080_0005, 32'h0000_2007, 32'h0000_3017);
    op(2'd2);
    step();
    op(2'd0);
    cq.push_back('{index: 32'd7, hi: 32'h0080_0005, lo0: 32'h0000_2007, lo1: 32'h0000_3017});
    step();
    op(2'd1);
    cq.push_back('{index: 32'h17, hi: 32'h0080_0005, lo0: 32'h0000_2007, lo1: 32'h0000_3017});
    step();
    cp0_entryhi = 32'h0000_0009;
    dreq(32'h0080_1ABC, 1'b0, ok(32'h000C_0ABC, 1'b1));
    ireq(32'h0080_0ABC, ok(32'h0008_0ABC, 1'b0));
    step();

    // Unmapped segments and kseg2
    dreq(32'hA000_1000, 1'b0, ok(32'h0000_1000, 1'b1));
    ireq(32'h8000_1000, ok(32'h0000_1000, 1'b0));
    step();
    dreq(32'hC000_1000, 1'b0, fault(1'b1, 1'b0, 1'b0));
    step();

    // Rewrite entry 3 with D=0 while a store looks up the old mapping
    set_cp0(32'd3, 32'h0040_0005, 32'h0000_1012, 32'h0);
    op(2'd2);
    dreq(32'h0040_0000, 1'b1, ok(32'h0004_0000, 1'b1));
    step();
    dreq(32'h0040_0000, 1'b1, fault(1'b0, 1'b0, 1'b1));
    step();
    dreq(32'h0040_0000, 1'b0, ok(32'h0004_0000, 1'b1));
    op(2'd1);
    cq.push_back('{index: 32'd3, hi: 32'h0040_0005, lo0: 32'h0000_1012, lo1: 32'h0});
    step();

    // Reset right after a probe: its pulse must be suppressed
    op(2'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (w_cp0_mmu_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_kills_pulse: got mmu_ena=%b, want 0", w_cp0_mmu_ena);
    end
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 2'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op(2'd0);
    cq.push_back('{index: 32'h8000_0000, hi: 32'h0040_0005, lo0: 32'h0000_1012, lo1: 32'h0});
    dreq(32'h0040_0123, 1'b0, fault(1'b1, 1'b0, 1'b0));
    step();

    repeat (3) @(negedge clk);
    check_empty("i_outstanding", iq.size());
    check_empty("d_outstanding", dq.size());
    check_empty("cp0_outstanding", cq.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
